// File: rtl/input_arb_pkg.sv
// Shared types and sizing helpers for the per-input-port VC arbiter.
package input_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    function automatic int unsigned vc_tot(input int unsigned vc_num, input int unsigned prio_num);
        return vc_num * prio_num;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/class_rr_picker.sv
// Picks the first requester at or after ptr within one priority class, wrapping.
module class_rr_picker
    import input_arb_pkg::*;
#(
    parameter  int unsigned vc_num = 3,
    localparam int unsigned PW     = idx_w(vc_num)
) (
    input  logic [vc_num-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic              valid,
    output logic [PW-1:0]     idx
);

    int unsigned cand;
    logic [PW-1:0] cand_idx;

    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < vc_num; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= vc_num) cand = cand - vc_num;
            cand_idx = PW'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/input_vc_arbiter.sv
// Input-port VC arbiter: class priority, then round-robin (INPUT_ARB_RR_EN) or
// lowest-index-first within a class; holds the chosen VC until its last flit.
module input_vc_arbiter
    import input_arb_pkg::*;
#(
    parameter  int unsigned vc_num     = 3,
    parameter  int unsigned prio_num   = 2,
    parameter  int unsigned output_num = 8,
    localparam int unsigned VC_TOT     = vc_tot(vc_num, prio_num),
    localparam int unsigned DW         = idx_w(output_num),
    localparam int unsigned VW         = idx_w(VC_TOT)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [VC_TOT-1:0]     i_has_packet,
    input  logic [output_num-1:0] i_dest      [VC_TOT],
    input  logic [VW-1:0]         i_output_vc [VC_TOT],
    input  logic                  i_last,
    input  logic                  i_gnt,
    output logic                  o_req,
    output logic [DW-1:0]         o_req_dest,
    output logic [VW-1:0]         o_req_output_vc,
    output logic [VW-1:0]         o_selected_vc,
    output logic                  o_cts,
    output logic                  o_busy
);

    localparam int unsigned PW = idx_w(vc_num);
    localparam int unsigned CW = idx_w(prio_num);

    arb_state_t state, state_n;

    logic [prio_num-1:0] cls_valid;
    logic [PW-1:0]       cls_idx [prio_num];
    logic [PW-1:0]       cls_ptr [prio_num];

    logic [VW-1:0] win_vc;
    logic          load;
    logic          grant_take;
    logic          cts_q;

    for (genvar p = 0; p < prio_num; p++) begin : g_cls
        class_rr_picker #(
            .vc_num(vc_num)
        ) u_pick (
            .req  (i_has_packet[p*vc_num +: vc_num]),
            .ptr  (cls_ptr[p]),
            .valid(cls_valid[p]),
            .idx  (cls_idx[p])
        );
    end

    // Later (higher) classes overwrite earlier ones, so the top non-empty class wins.
    always_comb begin
        win_vc = '0;
        for (int unsigned p = 0; p < prio_num; p++) begin
            if (cls_valid[p]) win_vc = VW'(p * vc_num + 32'(cls_idx[p]));
        end
    end

`ifdef INPUT_ARB_RR_EN
    logic [PW-1:0] rr_ptr [prio_num];
    logic [CW-1:0] sel_cls;
    logic [PW-1:0] next_off;
    int unsigned   sel_off;

    always_comb begin
        sel_cls  = CW'(32'(o_selected_vc) / vc_num);
        sel_off  = 32'(o_selected_vc) % vc_num;
        next_off = (sel_off + 1 == vc_num) ? '0 : PW'(sel_off + 1);
        for (int unsigned p = 0; p < prio_num; p++) cls_ptr[p] = rr_ptr[p];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned p = 0; p < prio_num; p++) rr_ptr[p] <= '0;
        end else if (grant_take) begin
            rr_ptr[sel_cls] <= next_off;
        end
    end
`else
    always_comb begin
        for (int unsigned p = 0; p < prio_num; p++) cls_ptr[p] = '0;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        grant_take = 1'b0;
        case (state)
            IDLE: begin
                if (|i_has_packet) begin
                    load    = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                // Withdrawal takes precedence over a same-cycle grant.
                if (!i_has_packet[o_selected_vc]) begin
                    state_n = IDLE;
                end else if (i_gnt) begin
                    grant_take = 1'b1;
                    state_n    = XFER;
                end
            end
            XFER: begin
                if (i_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_selected_vc   <= '0;
            o_req_dest      <= '0;
            o_req_output_vc <= '0;
            cts_q           <= 1'b0;
        end else begin
            cts_q <= grant_take;
            if (load) begin
                o_selected_vc   <= win_vc;
                o_req_dest      <= i_dest[win_vc][DW-1:0];
                o_req_output_vc <= i_output_vc[win_vc];
            end
        end
    end

    if (output_num > DW) begin : g_dest_hi
        logic dest_hi_unused;
        always_comb begin
            dest_hi_unused = 1'b0;
            for (int unsigned v = 0; v < VC_TOT; v++) begin
                dest_hi_unused = dest_hi_unused ^ (^i_dest[v][output_num-1:DW]);
            end
        end
    end

    assign o_req  = (state == REQ);
    assign o_busy = (state != IDLE);
    assign o_cts  = cts_q;

endmodule

// File: tb/tb_input_vc_arbiter.sv
// Self-checking bench for input_vc_arbiter (default 3 VCs x 2 classes, 8 outputs).
module tb_input_vc_arbiter;

    localparam int VCN  = 3;
    localparam int PRIO = 2;
    localparam int TOT  = VCN * PRIO;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] has;
    logic [7:0] dest [TOT];
    logic [2:0] ovc  [TOT];
    logic       i_last;
    logic       i_gnt;
    logic       o_req;
    logic [2:0] o_req_dest;
    logic [2:0] o_req_output_vc;
    logic [2:0] o_selected_vc;
    logic       o_cts;
    logic       o_busy;

    int total = 0;
    int bad   = 0;
    int mptr [PRIO];

    input_vc_arbiter #(
        .vc_num    (VCN),
        .prio_num  (PRIO),
        .output_num(8)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .i_has_packet   (has),
        .i_dest         (dest),
        .i_output_vc    (ovc),
        .i_last         (i_last),
        .i_gnt          (i_gnt),
        .o_req          (o_req),
        .o_req_dest     (o_req_dest),
        .o_req_output_vc(o_req_output_vc),
        .o_selected_vc  (o_selected_vc),
        .o_cts          (o_cts),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference choice: highest class first, then first set VC from the class pointer.
    function automatic int model_pick(input logic [5:0] h);
        for (int c = PRIO - 1; c >= 0; c--) begin
            for (int k = 0; k < VCN; k++) begin
                int v;
                v = c * VCN + (mptr[c] + k) % VCN;
                if (((h >> v) & 6'd1) != 6'd0) return v;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < PRIO; c++) mptr[c] = 0;
    endtask

    task automatic model_grant(input int v);
`ifdef INPUT_ARB_RR_EN
        mptr[v / VCN] = (v % VCN + 1) % VCN;
`else
        if (v < 0) mptr[0] = 0;
`endif
    endtask

    // Runs one packet starting from IDLE with the request inputs already applied.
    task automatic packet(input int exp_vc, input int flits, input int hold);
        int         ev;
        logic [2:0] ed;
        logic [2:0] eo;
        ev = (exp_vc >= 0) ? exp_vc : model_pick(has);
        ed = dest[ev][2:0];
        eo = ovc[ev];
        tick();
        chk("req_high", o_req, 1);
        chk("sel_vc", o_selected_vc, ev);
        chk("req_dest", o_req_dest, ed);
        chk("req_ovc", o_req_output_vc, eo);
        chk("busy_req", o_busy, 1);
        for (int h = 0; h < hold; h++) begin
            dest[ev] = 8'($urandom);
            ovc[ev]  = 3'($urandom_range(0, 5));
            i_last   = 1'($urandom);
            tick();
            i_last = 1'b0;
            chk("hold_req", o_req, 1);
            chk("frozen_dest", o_req_dest, ed);
            chk("frozen_ovc", o_req_output_vc, eo);
            chk("hold_cts", o_cts, 0);
        end
        i_gnt = 1'b1;
        tick();
        i_gnt = 1'b0;
        model_grant(ev);
        chk("xfer_req", o_req, 0);
        chk("cts_pulse", o_cts, 1);
        chk("busy_xfer", o_busy, 1);
        for (int k = 1; k < flits; k++) begin
            tick();
            chk("cts_once", o_cts, 0);
            chk("busy_body", o_busy, 1);
        end
        i_last = 1'b1;
        tick();
        i_last = 1'b0;
        chk("idle_busy", o_busy, 0);
        chk("idle_req", o_req, 0);
    endtask

    initial begin
        int rr_seq [4];
        resetn = 1'b0;
        has    = '0;
        i_last = 1'b0;
        i_gnt  = 1'b0;
        for (int v = 0; v < TOT; v++) begin
            dest[v] = 8'($urandom);
            ovc[v]  = 3'($urandom_range(0, 5));
        end
        model_reset();
        #1;
        chk("reset_outputs", {o_req, o_req_dest, o_req_output_vc, o_selected_vc, o_cts, o_busy}, 0);
        tick();
        tick();
        resetn = 1'b1;

        // Single request, with inputs changing while the request is held.
        has     = 6'b000100;
        dest[2] = 8'd5;
        ovc[2]  = 3'd3;
        packet(2, 3, 2);

        // Class 1 beats class 0.
        has = 6'b001001;
        packet(3, 2, 0);
        has = 6'b000001;
        packet(0, 1, 1);

        // Reset asserted mid-packet acts immediately.
        has = 6'b000100;
        tick();
        chk("pre_rst_req", o_req, 1);
        i_gnt = 1'b1;
        tick();
        i_gnt = 1'b0;
        chk("pre_rst_cts", o_cts, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset", {o_req, o_req_dest, o_req_output_vc, o_selected_vc, o_cts, o_busy}, 0);
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
        chk("post_reset_idle", o_busy, 0);

        // Continuous requests on all of class 0; third packet is single-flit.
`ifdef INPUT_ARB_RR_EN
        rr_seq = '{0, 1, 2, 0};
`else
        rr_seq = '{0, 0, 0, 0};
`endif
        has = 6'b000111;
        packet(rr_seq[0], 2, 1);
        packet(rr_seq[1], 3, 0);
        packet(rr_seq[2], 1, 0);
        packet(rr_seq[3], 1, 0);

        // Withdrawal together with a grant: withdrawal wins, pointer untouched.
        has = 6'b000010;
        tick();
        chk("wd_req", o_req, 1);
        chk("wd_sel", o_selected_vc, 1);
        has   = 6'b000000;
        i_gnt = 1'b1;
        tick();
        i_gnt = 1'b0;
        chk("wd_req_drop", o_req, 0);
        chk("wd_idle", o_busy, 0);
        chk("wd_no_cts", o_cts, 0);
        has = 6'b000011;
        packet(-1, 1, 0);

        // Randomized traffic against the reference choice.
        for (int n = 0; n < 40; n++) begin
            has = 6'($urandom_range(1, 63));
            for (int v = 0; v < TOT; v++) begin
                dest[v] = 8'($urandom);
                ovc[v]  = 3'($urandom_range(0, 5));
            end
            packet(-1, $urandom_range(1, 3), $urandom_range(0, 2));
        end

        has = '0;
        tick();
        chk("final_idle", o_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_vc_arbiter.md
# input_vc_arbiter

Per-input-port arbiter that picks one virtual channel (VC) with a pending packet, requests that packet's output port and output VC from the switch allocator, and holds the choice until the packet's last flit has left. It sits between the per-VC input buffers, which supply `i_has_packet`, `i_dest` and `i_output_vc`, and the output allocator. It also returns `o_selected_vc` and `o_cts` to the buffers, so that the chosen VC starts draining.

## Interface
Parameters:
- `vc_num`, default 3: VCs per priority class.
- `prio_num`, default 2: number of priority classes. `VC_TOT = vc_num*prio_num`.
- `output_num`, default 8: switch output ports.

Ports:
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `i_has_packet` in `VC_TOT`: bit v set means VC v holds at least one complete packet header.
- `i_dest` in `output_num` × `VC_TOT` (unpacked): destination port index of VC v's head packet. Only the low `$clog2(output_num)` bits are used.
- `i_output_vc` in `$clog2(VC_TOT)` × `VC_TOT` (unpacked): requested output VC of the head packet.
- `i_last` in 1: the selected VC is transferring its last flit this cycle.
- `i_gnt` in 1: the allocator accepts the current request.
- `o_req` out 1: request valid.
- `o_req_dest` out `$clog2(output_num)`: registered destination.
- `o_req_output_vc` out `$clog2(VC_TOT)`: registered output VC.
- `o_selected_vc` out `$clog2(VC_TOT)`: VC currently chosen.
- `o_cts` out 1: clear-to-send pulse to the buffer of `o_selected_vc`.
- `o_busy` out 1: the arbiter is in the REQ or XFER state.

## Operation
- Priority class of VC v is `v / vc_num`. Class `prio_num-1` is the highest and always wins over lower classes.
- Within a class, a round-robin pointer `ptr[p]` selects the first requesting VC at or after the pointer, wrapping inside the class.
- FSM states: IDLE, REQ, XFER.
  - IDLE: if any `i_has_packet` bit is set, arbitrate. Register the winner into `o_selected_vc`, its `i_dest` into `o_req_dest` and its `i_output_vc` into `o_req_output_vc`, then go to REQ. Otherwise stay in IDLE.
  - REQ: `o_req`=1.
    - If `i_has_packet[o_selected_vc]` drops, go to IDLE. No pointer update.
    - Otherwise, if `i_gnt`=1, go to XFER and set `ptr[class]` to `o_selected_vc+1`, wrapped within the class.
    - Otherwise hold. The request contents stay frozen even if the inputs change.
  - XFER: `o_req`=0. `o_cts`=1 in the first XFER cycle only. Stay until `i_last`=1, then go to IDLE.
- `i_last` is ignored outside XFER.
- `o_busy` is 1 in the REQ and XFER states.
- Reset values: every output is 0, the state is IDLE, and all `ptr` values are 0. Asserting `resetn` low at any time, including in the middle of a packet, returns the block to these values immediately.

## Timing
- Arbitration to `o_req`: 1 cycle. Inputs are sampled in IDLE and `o_req` is high in the following cycle.
- `i_gnt` to `o_cts`: 1 cycle.
- `i_last` to IDLE: 1 cycle. The next `o_req` follows 1 cycle later, giving a minimum 2-cycle gap between packets.
- A single-flit packet asserts `i_last` in the first XFER cycle, together with `o_cts`. The FSM leaves XFER in the next cycle.
- If a withdrawal and `i_gnt` occur in the same REQ cycle, the withdrawal wins and the grant is ignored.

## Configuration
- `INPUT_ARB_RR_EN` defined: round-robin within each class, as described above.
- `INPUT_ARB_RR_EN` undefined: fixed priority within a class, where the lowest VC index wins. The pointer registers are not instantiated.

## Structure
- A shared package `input_arb_pkg` holds the state enum (`IDLE`/`REQ`/`XFER`) and a `VC_TOT` helper function.
- One sub-module, `class_rr_picker`: picks one requester from a `vc_num`-wide request vector and a pointer. It is instantiated once per class, and the top level selects the highest non-empty class.

## Test plan
- Reset: drive `resetn`=0 while in XFER. All outputs must go to 0 asynchronously, and after release the state must be IDLE with `ptr`=0.
- Single request: `i_has_packet`=6'b000100, `i_dest[2]`=5, `i_output_vc[2]`=3. Expect `o_req`=1 one cycle later with `o_req_dest`=5, `o_req_output_vc`=3 and `o_selected_vc`=2. After `i_gnt`, expect an `o_cts` pulse; after `i_last`, expect IDLE.
- Class priority: `i_has_packet`=6'b001001 (VC0 in class 0, VC3 in class 1). Expect VC3 to be selected first, then VC0.
- Round-robin: class 0 with VCs 0, 1 and 2 requesting continuously gives the grant order 0, 1, 2, 0. With the macro undefined, the order is 0, 0, 0.
- Withdrawal: in REQ, drop `i_has_packet[sel]`. Expect `o_req`=0 the next cycle, IDLE, and the pointer unchanged.
- Single-flit packet: assert `i_last` together with `o_cts` in the first XFER cycle. Expect IDLE the next cycle and a new `o_req` one cycle after that.
